// File: rtl/tanh_grad_unit_pkg.sv
// Shared fixed-point definitions for the tanh backward-pass blocks (Q2.6 at defaults).
// Widths, the fixed-point one constant and the output saturation helper live here.
package tanh_grad_unit_pkg;

   localparam int unsigned DATA_W = 9;
   localparam int unsigned FRAC_W = 6;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned PROD_W = 2 * DATA_W + 1;

   localparam int FP_ONE  = 1 << FRAC_W;
   localparam int RND_ADD = 1 << (FRAC_W - 1);
   localparam int SAT_MAX = (1 << (DATA_W - 1)) - 1;
   localparam int SAT_MIN = -SAT_MAX - 1;

   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [PROD_W-1:0] v);
      logic signed [DATA_W-1:0] res;
      if (v > PROD_W'(SAT_MAX)) begin
         res = DATA_W'(SAT_MAX);
      end else if (v < PROD_W'(SAT_MIN)) begin
         res = DATA_W'(SAT_MIN);
      end else begin
         res = v[DATA_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/tanh_grad_unit_fxp_mul_round.sv
// Signed fixed-point multiply with a registered product, then round-half-up shift
// and saturation back to DATA_W. The product register is the S2 pipeline stage.
module tanh_grad_unit_fxp_mul_round
   import tanh_grad_unit_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     adv,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] r
);

   logic signed [PROD_W-1:0] a_ext, b_ext;
   logic signed [PROD_W-1:0] p_d, p_q;
   logic signed [PROD_W-1:0] p_rnd;
   logic                     valid_d, valid_q;

   always_comb begin
      a_ext   = {{(PROD_W - DATA_W){a[DATA_W-1]}}, a};
      b_ext   = {{(PROD_W - DATA_W){b[DATA_W-1]}}, b};
      p_d     = p_q;
      valid_d = valid_q;
      if (adv) begin
         p_d     = a_ext * b_ext;
         valid_d = in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         p_q     <= p_d;
         valid_q <= valid_d;
      end
   end

   // Arithmetic shift floors, so adding half an LSB first gives round-half-up.
   always_comb begin
      p_rnd     = (p_q + PROD_W'(RND_ADD)) >>> FRAC_W;
      r         = sat_data(p_rnd);
      out_valid = valid_q;
   end

endmodule

// File: rtl/tanh_grad_unit.sv
// Local tanh gradient g_out = g_in * (1 - y^2), three-stage valid/ready pipeline.
// Define TANH_GRAD_CLAMP_CNT_EN to add the clamp_cnt event counter port.
module tanh_grad_unit
   import tanh_grad_unit_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] y_in,
   input  logic signed [DATA_W-1:0] g_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] g_out
`ifdef TANH_GRAD_CLAMP_CNT_EN
   ,
   output logic [CNT_W-1:0]         clamp_cnt
`endif
);

   logic                     adv;
   logic signed [PROD_W-1:0] y_ext, ysq, d_full;
   logic signed [DATA_W-1:0] d;
   logic                     clamp;

   logic                     s1_valid_d, s1_valid_q;
   logic signed [DATA_W-1:0] s1_g_d, s1_g_q;
   logic signed [DATA_W-1:0] s1_d_d, s1_d_q;

   logic                     s2_valid;
   logic signed [DATA_W-1:0] s2_r;

   logic                     out_valid_d, out_valid_q;
   logic signed [DATA_W-1:0] g_out_d, g_out_q;

   // Whole pipeline moves as one; a full output register blocks every stage.
   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv;

   // S1: d = 1 - y^2, clamped at zero when |y| exceeds one.
   always_comb begin
      y_ext  = {{(PROD_W - DATA_W){y_in[DATA_W-1]}}, y_in};
      ysq    = (y_ext * y_ext) >>> FRAC_W;
      d_full = PROD_W'(FP_ONE) - ysq;
      clamp  = d_full < PROD_W'(0);
      d      = clamp ? '0 : d_full[DATA_W-1:0];

      s1_valid_d = s1_valid_q;
      s1_g_d     = s1_g_q;
      s1_d_d     = s1_d_q;
      if (adv) begin
         s1_valid_d = in_valid;
         s1_g_d     = g_in;
         s1_d_d     = d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_g_q     <= '0;
         s1_d_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_g_q     <= s1_g_d;
         s1_d_q     <= s1_d_d;
      end
   end

   tanh_grad_unit_fxp_mul_round u_mul_round (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .in_valid  (s1_valid_q),
      .a         (s1_g_q),
      .b         (s1_d_q),
      .out_valid (s2_valid),
      .r         (s2_r)
   );

   // S3: output register, held while downstream stalls.
   always_comb begin
      out_valid_d = out_valid_q;
      g_out_d     = g_out_q;
      if (adv) begin
         out_valid_d = s2_valid;
         g_out_d     = s2_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         g_out_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         g_out_q     <= g_out_d;
      end
   end

   assign out_valid = out_valid_q;
   assign g_out     = g_out_q;

`ifdef TANH_GRAD_CLAMP_CNT_EN
   logic [CNT_W-1:0] clamp_cnt_d, clamp_cnt_q;

   always_comb begin
      clamp_cnt_d = clamp_cnt_q;
      if (in_valid && adv && clamp && !(&clamp_cnt_q)) begin
         clamp_cnt_d = clamp_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clamp_cnt_q <= '0;
      end else begin
         clamp_cnt_q <= clamp_cnt_d;
      end
   end

   assign clamp_cnt = clamp_cnt_q;
`endif

endmodule

// File: tb/tb_tanh_grad_unit.sv
// Directed bench for tanh_grad_unit: single beats, rounding, clamping, backpressure
// and mid-stream reset, with hand-computed expected values.
module tb_tanh_grad_unit;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [8:0] y_in;
   logic signed [8:0] g_in;
   logic              out_valid;
   logic              out_ready;
   logic signed [8:0] g_out;
`ifdef TANH_GRAD_CLAMP_CNT_EN
   logic [15:0]       clamp_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tanh_grad_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y_in      (y_in),
      .g_in      (g_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .g_out     (g_out)
`ifdef TANH_GRAD_CLAMP_CNT_EN
      ,
      .clamp_cnt (clamp_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One beat with out_ready high; checks 3-cycle latency and the result.
   task automatic send(input string tag, input int y, input int g, input int exp);
      int cycles;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      y_in      = 9'(y);
      g_in      = 9'(g);
      step();
      in_valid = 1'b0;
      cycles   = 1;
      while (!out_valid && cycles < 10) begin
         step();
         cycles++;
      end
      check({tag, "_lat"}, cycles, 3);
      check(tag, int'(g_out), exp);
      step();
   endtask

   int ty[8] = '{0, 32, -32, 64, 32, 32, 100, 8};
   int tg[8] = '{64, 64, 64, 100, 3, -255, 50, 100};
   int te[8] = '{64, 48, 48, 0, 2, -191, 0, 98};

   initial begin
      logic [31:0]       pat;
      int                sent;
      int                rcvd;
      logic              stall;
      logic signed [8:0] held;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      y_in      = '0;
      g_in      = '0;
      step();
      step();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_g_out", int'(g_out), 0);
      check("rst_in_ready", int'(in_ready), 1);
`ifdef TANH_GRAD_CLAMP_CNT_EN
      check("rst_clamp_cnt", int'(clamp_cnt), 0);
`endif
      rst = 1'b0;
      step();

      send("y0_g64", 0, 64, 64);
      send("y32_g64", 32, 64, 48);
      send("yn32_g64", -32, 64, 48);
      send("y64_g100", 64, 100, 0);
      send("yn64_g100", -64, 100, 0);
      send("rnd_pos", 32, 3, 2);
      send("rnd_neg", 32, -3, -2);
      send("rnd_n255", 32, -255, -191);
      send("clamp_y100", 100, 50, 0);
      send("clamp_yn256", -256, 100, 0);
      send("y0_gmin", 0, -256, -256);
      send("y0_gmax", 0, 255, 255);
      send("y8_g100", 8, 100, 98);

      // Backpressure stream; the pattern is read LSB first and has many low cycles.
      pat  = 32'b1011_0110_1100_1101_0011_1010_0110_0101;
      sent = 0;
      rcvd = 0;
      for (int c = 0; c < 80 && rcvd < 8; c++) begin
         in_valid = (sent < 8);
         if (sent < 8) begin
            y_in = 9'(ty[sent]);
            g_in = 9'(tg[sent]);
         end
         out_ready = pat[c % 32];
         #1;
         stall = out_valid && !out_ready;
         held  = g_out;
         if (out_valid && out_ready) begin
            check("stream_val", int'(g_out), te[rcvd]);
            rcvd++;
         end
         if (in_valid && in_ready) sent++;
         step();
         if (stall) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_hold", int'(g_out), int'(held));
         end
      end
      check("stream_sent", sent, 8);
      check("stream_rcvd", rcvd, 8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("stream_drained", int'(out_valid), 0);

      // Mid-stream reset with three beats in flight, one of them clamping.
      in_valid  = 1'b1;
      y_in      = 9'sd100;
      g_in      = 9'sd50;
      step();
      y_in      = 9'sd0;
      g_in      = 9'sd64;
      step();
      g_in      = 9'sd10;
      step();
      in_valid  = 1'b0;
      rst       = 1'b1;
      step();
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_g_out", int'(g_out), 0);
      check("midrst_in_ready", int'(in_ready), 1);
`ifdef TANH_GRAD_CLAMP_CNT_EN
      check("midrst_clamp_cnt", int'(clamp_cnt), 0);
`endif
      rst = 1'b0;
      step();
      check("midrst_no_ghost", int'(out_valid), 0);
      send("post_rst", 32, 64, 48);

`ifdef TANH_GRAD_CLAMP_CNT_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("cnt_start", int'(clamp_cnt), 0);
      send("cnt_beat1", 100, 50, 0);
      check("cnt_one", int'(clamp_cnt), 1);
      send("cnt_noclamp", 64, 50, 0);
      check("cnt_still_one", int'(clamp_cnt), 1);
      for (int i = 0; i < 9; i++) begin
         send("cnt_beat", 100, 50, 0);
      end
      check("cnt_ten", int'(clamp_cnt), 10);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
